// File: rtl/mux_4_to_1_pkg.sv
// Select-code constants and type shared by the data-steering blocks.
package mux_4_to_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4_to_1_comb.sv
// Purely combinational 4:1 word selector; no state, no arithmetic.
module mux_4_to_1_comb
  import mux_4_to_1_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic [DATA_WIDTH-1:0] D,
  input  sel_t                  Select,
  output logic [DATA_WIDTH-1:0] sel_word
);

  // Fully decoded select; every code maps to exactly one source.
  always_comb begin
    sel_word = A;
    case (Select)
      SEL_A: sel_word = A;
      SEL_B: sel_word = B;
      SEL_C: sel_word = C;
      SEL_D: sel_word = D;
    endcase
  end

endmodule

// File: rtl/mux_4_to_1.sv
// 4:1 data selector with registered word and valid outputs (1-cycle latency).
module mux_4_to_1
  import mux_4_to_1_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [1:0]            Select,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] E,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] sel_word;

  mux_4_to_1_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_comb (
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .Select  (sel_t'(Select)),
    .sel_word(sel_word)
  );

  // Output register: reset clears, a valid input loads, otherwise E holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      E         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        E <= sel_word;
      end
    end
  end

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed and random checks of mux_4_to_1 at DATA_WIDTH 2 and 32.
module tb_mux_4_to_1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  sel;
  logic [1:0]  a2, b2, c2, d2;
  logic [31:0] a32, b32, c32, d32;
  logic [1:0]  e2;
  logic [31:0] e32;
  logic        ov2, ov32;

  int checks = 0;
  int failures = 0;

  logic [1:0]  m_e2;
  logic [31:0] m_e32;
  logic        m_v;

  mux_4_to_1 #(.DATA_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .A(a2), .B(b2), .C(c2), .D(d2),
    .Select(sel), .in_valid(in_valid),
    .E(e2), .out_valid(ov2)
  );

  mux_4_to_1 #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .A(a32), .B(b32), .C(c32), .D(d32),
    .Select(sel), .in_valid(in_valid),
    .E(e32), .out_valid(ov32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, then check both DUTs.
  task automatic step(input logic rst, input logic vld, input logic [1:0] s, input string tag);
    logic [1:0]  w2 [4];
    logic [31:0] w32[4];
    @(negedge clk);
    rst_n    = rst;
    in_valid = vld;
    sel      = s;
    w2  = '{a2, b2, c2, d2};
    w32 = '{a32, b32, c32, d32};
    if (!rst) begin
      m_e2  = '0;
      m_e32 = '0;
      m_v   = 1'b0;
    end else begin
      if (vld) begin
        m_e2  = w2[s];
        m_e32 = w32[s];
      end
      m_v = vld;
    end
    @(posedge clk);
    #1;
    check({tag, " E w2"},  {30'b0, e2}, {30'b0, m_e2});
    check({tag, " ov w2"}, {31'b0, ov2}, {31'b0, m_v});
    check({tag, " E w32"}, e32, m_e32);
    check({tag, " ov w32"}, {31'b0, ov32}, {31'b0, m_v});
  endtask

  initial begin
    m_e2 = '0; m_e32 = '0; m_v = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'b00;
    a2 = 2'b11; b2 = '0; c2 = '0; d2 = '0;
    a32 = 32'hFFFF_FFFF; b32 = '0; c32 = '0; d32 = '0;

    // Reset held with valid input present
    step(1'b0, 1'b1, 2'b00, "reset0");
    step(1'b0, 1'b1, 2'b00, "reset1");
    check("reset const E w2", {30'b0, e2}, 32'd0);

    // Select sweep
    a2 = 2'b00; b2 = 2'b01; c2 = 2'b10; d2 = 2'b11;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; c32 = 32'h0; d32 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), "sweep");
    check("sweep last E w32", e32, 32'hFFFF_FFFF);

    // Mid-stream reset
    step(1'b1, 1'b1, 2'b00, "mid_pre");
    step(1'b1, 1'b1, 2'b01, "mid_pre");
    step(1'b0, 1'b1, 2'b10, "mid_rst");
    check("mid_rst const ov", {31'b0, ov2}, 32'd0);
    step(1'b1, 1'b1, 2'b11, "mid_resume");
    step(1'b1, 1'b1, 2'b00, "mid_resume");

    // Hold when in_valid drops
    step(1'b1, 1'b1, 2'b10, "hold_cap");
    c2 = 2'b00; c32 = 32'hA5A5_A5A5;
    step(1'b1, 1'b0, 2'b01, "hold");
    step(1'b1, 1'b0, 2'b10, "hold");
    check("hold const E w2", {30'b0, e2}, 32'd2);

    // Back-to-back data toggling on D
    for (int i = 0; i < 6; i++) begin
      d2  = (i % 2 == 0) ? 2'b11 : 2'b00;
      d32 = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      step(1'b1, 1'b1, 2'b11, "toggle");
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a2 = 2'($urandom); b2 = 2'($urandom); c2 = 2'($urandom); d2 = 2'($urandom);
      a32 = $urandom; b32 = $urandom; c32 = $urandom; d32 = $urandom;
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
